// File: rtl/fp64_log2_seq_pkg.sv
// Shared types and constants for the iterative binary64 log2 unit.
package fp64_log2_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIFY,
    S_ITER,
    S_PACK
  } state_t;

  // Width of the signed integer part of the fixed-point result (exponent range -1074..1023)
  localparam int LOG_INT_BITS = 12;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] FP64_PINF = 64'h7FF0000000000000;
  localparam logic [63:0] FP64_NINF = 64'hFFF0000000000000;
  localparam logic [63:0] FP64_ONE  = 64'h3FF0000000000000;

  // Quiet a NaN operand: force positive sign and the quiet bit, keep the payload
  function automatic logic [63:0] nan_quiet(input logic [63:0] a);
    return {1'b0, 11'h7FF, 1'b1, a[50:0]};
  endfunction

endpackage

// File: rtl/fp64_log2_seq_if.sv
// Start/done handshake and operand/result bundle for the log2 unit.
interface fp64_log2_seq_if;
  logic        start;
  logic [63:0] a;
  logic        busy;
  logic        done;
  logic [63:0] y;
  logic        invalid;
  logic        div_by_zero;
  logic        inexact;

  modport master (
    output start, a,
    input  busy, done, y, invalid, div_by_zero, inexact
  );

  modport slave (
    input  start, a,
    output busy, done, y, invalid, div_by_zero, inexact
  );
endinterface

// File: rtl/fp64_log2_seq_fix2fp_pack.sv
// Signed fixed-point (INT_BITS.FRAC_BITS, two's complement) to binary64 with
// normalisation and round-to-nearest-even. Purely combinational.
module fp64_fix2fp_pack #(
  parameter int INT_BITS  = 12,
  parameter int FRAC_BITS = 60
) (
  input  logic signed [INT_BITS+FRAC_BITS-1:0] fix,
  output logic        [63:0]                   y,
  output logic                                 rounded
);

  localparam int W = INT_BITS + FRAC_BITS;
  // Biased exponent when the leading one sits in the MSB of the magnitude
  localparam logic [10:0] EXP_TOP = 11'(W - 1 - FRAC_BITS + 1023);

  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  logic          sgn;
  logic [W-1:0]  mag;
  logic [W-1:0]  norm;
  logic [6:0]    lz;
  logic [52:0]   mant;
  logic          guard;
  logic          sticky;
  logic [53:0]   sum;
  logic [10:0]   exp_b;
  logic [51:0]   frac_o;

  // Magnitude, leading-zero count, normalise, round and assemble
  always_comb begin
    sgn = fix[W-1];
    // The most negative value wraps onto itself, which is the correct unsigned magnitude
    mag = sgn ? $unsigned(-fix) : $unsigned(fix);
    lz  = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) lz = 7'(W - 1 - i);
    end
    norm   = mag << lz;
    mant   = norm[W-1 -: 53];
    guard  = norm[W-54];
    sticky = |norm[W-55:0];
    sum    = {1'b0, mant} + {53'b0, rne_up(mant[0], guard, sticky)};
    // Rounding carry-out leaves 1.000..0, so only the exponent moves
    exp_b  = EXP_TOP - {4'b0, lz} + {10'b0, sum[53]};
    frac_o = sum[53] ? sum[52:1] : sum[51:0];
    if (mag == '0) begin
      y       = '0;
      rounded = 1'b0;
    end else begin
      y       = {sgn, exp_b, frac_o};
      rounded = guard | sticky;
    end
  end

endmodule

// File: rtl/fp64_log2_seq.sv
// Iterative binary64 log2: classify, develop one fraction bit per cycle by
// repeated squaring of the mantissa, then pack the fixed-point result.
module fp64_log2_seq
  import fp64_log2_seq_pkg::*;
#(
  parameter int FRAC_BITS = 60
) (
  input  logic            clk,
  input  logic            rst,
  fp64_log2_seq_if.slave  bus
);

  localparam int FIX_W = LOG_INT_BITS + FRAC_BITS;

  state_t state, state_next;

  logic [63:0]                    a_reg;
  logic [63:0]                    m_reg;
  logic signed [LOG_INT_BITS-1:0] int_reg;
  logic [FRAC_BITS-1:0]           frac_reg;
  logic                           pow2_reg;
  logic [5:0]                     cnt;

  logic        busy_q, done_q, inv_q, dz_q, inx_q;
  logic [63:0] y_q;

  logic        sgn;
  logic [10:0] ex;
  logic [51:0] fr;
  logic        is_nan, is_inf, is_zero, is_one, is_special;
  logic [63:0] spec_y;
  logic        spec_inv, spec_dz;
  logic [5:0]  sub_lz;
  logic [51:0] sub_fr;
  logic [63:0] m_init;
  logic signed [LOG_INT_BITS-1:0] e_init;
  logic        pow2_init;

  logic [1:0]  sq_unused_hi;
  logic [61:0] sq_unused_lo;
  logic [63:0] sq_q262;
  logic        sq_ge2;
  logic [63:0] m_next;

  logic signed [FIX_W-1:0] fix_val;
  logic [63:0]             pack_y;
  logic                    pack_rnd;

  // Operand decode: special-case results and normalised Q2.62 mantissa / exponent
  always_comb begin
    sgn        = a_reg[63];
    ex         = a_reg[62:52];
    fr         = a_reg[51:0];
    is_nan     = (ex == 11'h7FF) && (fr != '0);
    is_inf     = (ex == 11'h7FF) && (fr == '0);
    is_zero    = (ex == '0) && (fr == '0);
    is_one     = (a_reg == FP64_ONE);
    is_special = is_nan | is_zero | sgn | is_inf | is_one;

    spec_y   = '0;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (is_nan) begin
      spec_y   = nan_quiet(a_reg);
      spec_inv = ~fr[51];
    end else if (is_zero) begin
      spec_y  = FP64_NINF;
      spec_dz = 1'b1;
    end else if (sgn) begin
      spec_y   = FP64_QNAN;
      spec_inv = 1'b1;
    end else if (is_inf) begin
      spec_y = FP64_PINF;
    end

    // Subnormal: shift the leading one out into the hidden-bit position
    sub_lz = '0;
    for (int i = 0; i < 52; i++) begin
      if (fr[i]) sub_lz = 6'(51 - i);
    end
    sub_fr = fr << (sub_lz + 6'd1);

    if (ex != '0) begin
      m_init    = {2'b01, fr, 10'b0};
      e_init    = $signed({1'b0, ex}) - 12'sd1023;
      pow2_init = (fr == '0);
    end else begin
      m_init    = {2'b01, sub_fr, 10'b0};
      e_init    = -12'sd1023 - $signed({6'b0, sub_lz});
      pow2_init = (sub_fr == '0);
    end
  end

  // Squaring step: m*m in Q4.124, keep the truncated Q2.62 slice
  assign {sq_unused_hi, sq_q262, sq_unused_lo} = m_reg * m_reg;
  assign sq_ge2  = sq_q262[63];
  assign m_next  = sq_ge2 ? {1'b0, sq_q262[63:1]} : sq_q262;

  assign fix_val = {int_reg, frac_reg};

  fp64_fix2fp_pack #(
    .INT_BITS  (LOG_INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_pack (
    .fix     (fix_val),
    .y       (pack_y),
    .rounded (pack_rnd)
  );

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (bus.start) state_next = S_CLASSIFY;
      S_CLASSIFY: state_next = is_special ? S_IDLE : S_ITER;
      S_ITER:     if (cnt == 6'd0) state_next = S_PACK;
      S_PACK:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Handshake, iteration counter and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      y_q    <= '0;
      inv_q  <= 1'b0;
      dz_q   <= 1'b0;
      inx_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) busy_q <= 1'b1;
        end
        S_CLASSIFY: begin
          if (is_special) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            y_q    <= spec_y;
            inv_q  <= spec_inv;
            dz_q   <= spec_dz;
            inx_q  <= 1'b0;
          end else begin
            cnt <= 6'(FRAC_BITS - 1);
          end
        end
        S_ITER: begin
          cnt <= cnt - 6'd1;
        end
        S_PACK: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          y_q    <= pack_y;
          inv_q  <= 1'b0;
          dz_q   <= 1'b0;
          // Only an exact power of two yields an exactly representable log2
          inx_q  <= pack_rnd | ~pow2_reg;
        end
        default: ;
      endcase
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        if (bus.start) a_reg <= bus.a;
      end
      S_CLASSIFY: begin
        m_reg    <= m_init;
        int_reg  <= e_init;
        frac_reg <= '0;
        pow2_reg <= pow2_init;
      end
      S_ITER: begin
        m_reg    <= m_next;
        frac_reg <= {frac_reg[FRAC_BITS-2:0], sq_ge2};
      end
      default: ;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.y           = y_q;
  assign bus.invalid     = inv_q;
  assign bus.div_by_zero = dz_q;
  assign bus.inexact     = inx_q;

endmodule

// File: tb/tb_fp64_log2_seq.sv
// Bench for fp64_log2_seq: directed specials/powers of two, abort-by-reset,
// start-while-busy, and randomised operands against a real-valued log2 model.
module tb_fp64_log2_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp64_log2_seq_if bus();

  fp64_log2_seq #(.FRAC_BITS(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] last_y;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    n_tests++;
    d = got - exp;
    if (d < 0) d = -d;
    if ((tol == 0) ? (got != exp) : (d > tol)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Map a binary64 pattern onto a monotonic integer so ulp distance is a subtraction
  function automatic longint ordered(input logic [63:0] b);
    return b[63] ? -longint'({1'b0, b[62:0]}) : longint'(b);
  endfunction

  // Behavioural log2: special-operand rules, exact results for powers of two,
  // otherwise real-valued log2 from the math library.
  task automatic ref_model(input logic [63:0] x, output logic [63:0] ey,
                           output logic einv, output logic edz, output logic einx,
                           output logic espc, output logic exact, output real er);
    logic        sgn;
    logic [10:0] ex;
    logic [51:0] fr, nf;
    int          e2, p;
    real         mr;
    sgn = x[63]; ex = x[62:52]; fr = x[51:0];
    einv = 0; edz = 0; einx = 0; espc = 1; exact = 1; er = 0.0; ey = '0;
    if (ex == 11'h7FF && fr != 0) begin
      ey = {1'b0, 11'h7FF, 1'b1, fr[50:0]};
      einv = ~fr[51];
    end else if (ex == 0 && fr == 0) begin
      ey = 64'hFFF0000000000000; edz = 1;
    end else if (sgn) begin
      ey = 64'h7FF8000000000000; einv = 1;
    end else if (ex == 11'h7FF) begin
      ey = 64'h7FF0000000000000;
    end else if (x == 64'h3FF0000000000000) begin
      ey = '0;
    end else begin
      espc = 0;
      if (ex != 0) begin
        e2 = int'(ex) - 1023;
        nf = fr;
      end else begin
        p = 0;
        for (int i = 0; i < 52; i++) if (fr[i]) p = i;
        e2 = p - 1074;
        nf = fr << (52 - p);
      end
      mr = $bitstoreal({12'h3FF, nf});
      if (nf == 0) begin
        er = real'(e2);
        ey = $realtobits(er);
      end else begin
        exact = 0; einx = 1;
        if (e2 == 0 || e2 == -1) er = $ln($bitstoreal(x)) / $ln(2.0);
        else                     er = real'(e2) + $ln(mr) / $ln(2.0);
        ey = $realtobits(er);
      end
    end
  endtask

  // Issue one operation; lat counts edges with the accepting edge as edge 1
  task automatic run_op(input logic [63:0] x, input bit noise, output logic [63:0] gy,
                        output logic ginv, output logic gdz, output logic ginx, output int lat);
    @(negedge clk);
    bus.a = x; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    check("busy_after_accept", longint'(bus.busy), 1, 0);
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (noise && (lat == 5 || lat == 30)) begin
        bus.start = 1'b1;
        bus.a = {$urandom, $urandom};
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    gy = bus.y; ginv = bus.invalid; gdz = bus.div_by_zero; ginx = bus.inexact;
    check("busy_at_done", longint'(bus.busy), 0, 0);
  endtask

  task automatic do_test(input string tag, input logic [63:0] x, input bit noise);
    logic [63:0] ey, gy;
    logic        einv, edz, einx, espc, exact, ginv, gdz, ginx;
    real         er;
    int          lat, busy_seen;
    ref_model(x, ey, einv, edz, einx, espc, exact, er);
    run_op(x, noise, gy, ginv, gdz, ginx, lat);
    last_y = gy;
    check({tag, "_lat"}, lat, espc ? 2 : 63, 0);
    if (exact)
      check({tag, "_y"}, gy, ey, 0);
    else if (er >= 0.0625 || er <= -0.0625)
      check({tag, "_y_ulp"}, ordered(gy), ordered(ey), 4);
    else
      check({tag, "_y_abs"}, longint'($bitstoreal(gy) * 2.0**60), longint'(er * 2.0**60), 16);
    check({tag, "_inv"}, longint'(ginv), longint'(einv), 0);
    check({tag, "_dz"},  longint'(gdz),  longint'(edz),  0);
    check({tag, "_inx"}, longint'(ginx), longint'(einx), 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, longint'(bus.done), 0, 0);
    if (exact) check({tag, "_y_hold"}, bus.y, ey, 0);
    if (noise) begin
      busy_seen = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (bus.busy || bus.done) busy_seen++;
      end
      check({tag, "_no_queue"}, busy_seen, 0, 0);
    end
  endtask

  initial begin
    int done_seen;
    logic [63:0] x;
    int k;
    bus.start = 1'b0;
    bus.a     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(bus.busy), 0, 0);
    check("rst_done", longint'(bus.done), 0, 0);
    check("rst_y",    bus.y, 0, 0);
    check("rst_inv",  longint'(bus.invalid), 0, 0);
    check("rst_dz",   longint'(bus.div_by_zero), 0, 0);
    check("rst_inx",  longint'(bus.inexact), 0, 0);
    @(negedge clk) rst = 1'b0;

    do_test("eight",   64'h4020000000000000, 0);
    check("eight_spec", last_y, 64'h4008000000000000, 0);
    do_test("half",    64'h3FE0000000000000, 0);
    check("half_spec", last_y, 64'hBFF0000000000000, 0);
    do_test("three",   64'h4008000000000000, 0);
    check("three_spec", ordered(last_y), ordered(64'h3FF95C01A39FBD68), 2);
    do_test("minsub",  64'h0000000000000001, 0);
    check("minsub_spec", last_y, 64'hC090C80000000000, 0);
    do_test("maxsub",  64'h000FFFFFFFFFFFFF, 0);
    do_test("negzero", 64'h8000000000000000, 0);
    do_test("poszero", 64'h0000000000000000, 0);
    do_test("negone",  64'hBFF0000000000000, 0);
    do_test("pinf",    64'h7FF0000000000000, 0);
    do_test("ninf",    64'hFFF0000000000000, 0);
    do_test("qnan",    64'h7FF8000000000123, 0);
    do_test("snan",    64'hFFF0000000000001, 0);
    do_test("one",     64'h3FF0000000000000, 0);
    do_test("big2",    64'h7FE0000000000000, 0);
    do_test("maxfin",  64'h7FEFFFFFFFFFFFFF, 0);
    do_test("near1",   64'h3FF0000000000001, 0);

    // Abort mid-iteration with reset: no done may follow
    @(negedge clk);
    bus.a = 64'h4008000000000000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", longint'(bus.busy), 0, 0);
    check("abort_done", longint'(bus.done), 0, 0);
    check("abort_y",    bus.y, 0, 0);
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0, 0);
    do_test("restart8", 64'h4020000000000000, 1);
    do_test("restart3", 64'h4008000000000000, 1);

    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 10);
      x = {$urandom, $urandom};
      case (k)
        0, 1, 2, 3, 4: x = {1'b0, 11'($urandom_range(1, 2046)), x[51:0]};
        5:  x = {1'b0, 11'd1023, x[51:0] >> $urandom_range(0, 51)};
        6:  x = {1'b0, 11'd1022, ~(x[51:0] >> $urandom_range(0, 51))};
        7:  x = {12'h000, x[51:0] >> $urandom_range(0, 51)};
        8:  if ($urandom_range(0, 1) == 1) x = {1'b0, 11'($urandom_range(1, 2046)), 52'b0};
            else                           x = {12'h000, 52'b1 << $urandom_range(0, 51)};
        9:  x = {x[63], ($urandom_range(0, 1) == 1) ? 11'h7FF : 11'h000,
                 x[51:0] >> $urandom_range(0, 52)};
        default: x = {1'b1, 11'($urandom_range(1, 2046)), x[51:0]};
      endcase
      do_test("rnd", x, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
